// File: rtl/aud_dsp_interp_if.sv
// SRAM read port and DAC-side sample bus shared by the playback DSP and its neighbours.
// master = the DSP (drives address and sample), slave = SRAM/serializer side.
interface aud_dsp_interp_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 20
) ();
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_data;
    logic [DATA_W-1:0] dac_data;
    logic              daclrck;

    modport master (
        output sram_addr,
        input  sram_data,
        output dac_data,
        input  daclrck
    );

    modport slave (
        input  sram_addr,
        output sram_data,
        input  dac_data,
        output daclrck
    );
endinterface

// File: rtl/aud_dsp_interp.sv
// Playback DSP: steps SRAM addresses once per DAC LR-clock period and produces the DAC sample
// in normal, fast-skip, slow-hold or slow linear-interpolation modes.
module aud_dsp_interp #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned SPEED_W = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_pause,
    input  logic               i_stop,
    input  logic [1:0]         i_mode,
    input  logic [SPEED_W-1:0] i_speed,
    input  logic [ADDR_W-1:0]  i_stop_addr,
    output logic [1:0]         o_state,
    output logic               o_fin,
    aud_dsp_interp_if.master   bus
);

    localparam int unsigned DIFF_W = DATA_W + 1;
    localparam int unsigned PROD_W = DATA_W + SPEED_W + 2;
    localparam int unsigned NUM_W  = SPEED_W + 1;
    localparam int unsigned SUM_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_FAST   = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;
    localparam logic [1:0] MODE_INTERP = 2'b11;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  prev_q, prev_d;
    logic [SPEED_W-1:0] k_q, k_d;
    logic [DATA_W-1:0]  dac_q, dac_d;
    logic               fin_q, fin_d;
    logic               lrck_q;

    logic                     tick_c;
    logic                     end_c;
    logic                     last_c;
    logic [SPEED_W-1:0]       k_eff_c;
    logic [NUM_W-1:0]         n_c;
    logic signed [DIFF_W-1:0] diff_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] quot_c;
    logic [DATA_W-1:0]        interp_c;
    logic [SUM_W-1:0]         sum_c;
    logic [ADDR_W-1:0]        fast_addr_c;
    logic [ADDR_W-1:0]        addr_inc_c;
    logic                     unused_bits_c;

    // Falling edge of the LR clock marks one DAC sample period.
    assign tick_c = lrck_q & ~bus.daclrck;
    assign end_c  = (addr_q >= i_stop_addr);

    // Phase k past the current N (speed lowered mid-play) is treated as the final phase.
    assign n_c     = NUM_W'(i_speed) + NUM_W'(1);
    assign last_c  = (k_q >= i_speed);
    assign k_eff_c = last_c ? i_speed : k_q;

    assign diff_c   = $signed({bus.sram_data[DATA_W-1], bus.sram_data})
                    - $signed({prev_q[DATA_W-1], prev_q});
    assign prod_c   = $signed({{(PROD_W-DIFF_W){diff_c[DIFF_W-1]}}, diff_c})
                    * $signed({{(PROD_W-SPEED_W){1'b0}}, k_eff_c});
    assign quot_c   = prod_c / $signed({{(PROD_W-NUM_W){1'b0}}, n_c});
    // Quotient magnitude never exceeds |cur - prev|, so the low DATA_W bits are exact.
    assign interp_c = prev_q + quot_c[DATA_W-1:0];

    assign sum_c       = {1'b0, addr_q} + SUM_W'(n_c);
    assign fast_addr_c = (sum_c > {1'b0, i_stop_addr}) ? i_stop_addr : sum_c[ADDR_W-1:0];
    assign addr_inc_c  = addr_q + ADDR_W'(1);

    assign unused_bits_c = ^quot_c[PROD_W-1:DATA_W];

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        prev_d  = prev_q;
        k_d     = k_q;
        dac_d   = dac_q;
        fin_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                dac_d = '0;
                if (i_start && !i_stop && !i_pause) begin
                    state_d = ST_PLAY;
                    addr_d  = '0;
                    k_d     = '0;
                    prev_d  = '0;
                end
            end

            ST_PLAY: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                end else if (end_c) begin
                    state_d = ST_IDLE;
                    fin_d   = 1'b1;
                end else if (i_pause) begin
                    state_d = ST_PAUSE;
                end else if (tick_c) begin
                    case (i_mode)
                        MODE_NORMAL: begin
                            dac_d  = bus.sram_data;
                            addr_d = addr_inc_c;
                        end
                        MODE_FAST: begin
                            dac_d  = bus.sram_data;
                            addr_d = fast_addr_c;
                        end
                        MODE_HOLD: begin
                            dac_d = bus.sram_data;
                            if (last_c) begin
                                k_d    = '0;
                                addr_d = addr_inc_c;
                            end else begin
                                k_d = k_q + SPEED_W'(1);
                            end
                        end
                        MODE_INTERP: begin
                            // N == 1 has no intermediate phases: emit the current word directly.
                            dac_d = (i_speed == '0) ? bus.sram_data : interp_c;
                            if (last_c) begin
                                prev_d = bus.sram_data;
                                k_d    = '0;
                                addr_d = addr_inc_c;
                            end else begin
                                k_d = k_q + SPEED_W'(1);
                            end
                        end
                        default: begin
                            dac_d = dac_q;
                        end
                    endcase
                end
            end

            ST_PAUSE: begin
                dac_d = '0;
                if (i_stop) begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                    k_d     = '0;
                    prev_d  = '0;
                end else if (i_start && !i_pause) begin
                    state_d = ST_PLAY;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            prev_q  <= '0;
            k_q     <= '0;
            dac_q   <= '0;
            fin_q   <= 1'b0;
            lrck_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            prev_q  <= prev_d;
            k_q     <= k_d;
            dac_q   <= dac_d;
            fin_q   <= fin_d;
            lrck_q  <= bus.daclrck;
        end
    end

    assign o_state       = state_q;
    assign o_fin         = fin_q;
    assign bus.sram_addr = addr_q;
    assign bus.dac_data  = dac_q;

endmodule
